// File: rtl/vga_scanout_if.sv
// Framebuffer read bus between the scanout engine and pixel memory.
//   fb_rd_en   : read strobe (scanout -> memory)
//   fb_rd_addr : read address (scanout -> memory)
//   fb_rd_data : pixel returned a fixed number of clocks after the strobe
interface vga_scanout_if #(
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned PIX_BITS = 1
);
  logic                fb_rd_en;
  logic [ADDR_W-1:0]   fb_rd_addr;
  logic [PIX_BITS-1:0] fb_rd_data;

  modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
  modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/vga_scanout.sv
// VGA raster scanout: walks an h/v raster, fetches pixels from a framebuffer
// with fixed read latency, and emits pixel, syncs and a frame-start pulse
// aligned with the returned data.
//   CLK_VGA     : pixel clock
//   reset       : asynchronous active-low reset
//   enable      : run scanout; low returns the raster to (0,0) and idles
//   fb          : framebuffer read bus (master side)
//   VGA_pixel   : registered pixel, 0 outside the active area
//   hsync/vsync : registered syncs, asserted level set by *_POL
//   frame_start : one-clock pulse aligned with pixel (0,0)
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned PIX_BITS   = 1,
  parameter int unsigned SCALE      = 0,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                CLK_VGA,
  input  logic                reset,
  input  logic                enable,
  vga_scanout_if.master       fb,
  output logic [PIX_BITS-1:0] VGA_pixel,
  output logic                hsync,
  output logic                vsync,
  output logic                frame_start
);

  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // one extra count of headroom so the sync window end always fits
  localparam int unsigned H_W       = $clog2(H_TOTAL + 1);
  localparam int unsigned V_W       = $clog2(V_TOTAL + 1);
  localparam int unsigned H_SYNC_LO = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_HI = H_SYNC_LO + H_SYNC;
  localparam int unsigned V_SYNC_LO = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_HI = V_SYNC_LO + V_SYNC;
  localparam int unsigned LINE_PIX  = H_ACTIVE >> SCALE;

  logic [H_W-1:0]      h_cnt_q, h_cnt_d;
  logic [V_W-1:0]      v_cnt_q, v_cnt_d;
  logic                active_c, hsync_c, vsync_c, frame_start_c;
  logic [ADDR_W-1:0]   fb_rd_addr_q, fb_rd_addr_d;
  // stage 0 lines up with the read strobe, stage RD_LATENCY with returned data
  logic [RD_LATENCY:0] act_pipe_q, act_pipe_d;
  logic [RD_LATENCY:0] hs_pipe_q, hs_pipe_d;
  logic [RD_LATENCY:0] vs_pipe_q, vs_pipe_d;
  logic [RD_LATENCY:0] fs_pipe_q, fs_pipe_d;
  logic [PIX_BITS-1:0] pixel_q, pixel_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                frame_start_q, frame_start_d;

  // Raster counters; held at the origin while disabled
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (enable) begin
      if (h_cnt_q == H_W'(H_TOTAL - 1)) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + V_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + H_W'(1);
        v_cnt_d = v_cnt_q;
      end
    end
  end

  // Pre-pipeline timing decode, gated so a disabled raster reads as idle
  always_comb begin
    active_c      = enable && (h_cnt_q < H_W'(H_ACTIVE)) && (v_cnt_q < V_W'(V_ACTIVE));
    hsync_c       = enable && (h_cnt_q >= H_W'(H_SYNC_LO)) && (h_cnt_q < H_W'(H_SYNC_HI));
    vsync_c       = enable && (v_cnt_q >= V_W'(V_SYNC_LO)) && (v_cnt_q < V_W'(V_SYNC_HI));
    frame_start_c = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Read address (held between reads) and alignment pipeline
  always_comb begin
    fb_rd_addr_d = fb_rd_addr_q;
    if (active_c) begin
      fb_rd_addr_d = ADDR_W'(v_cnt_q >> SCALE) * ADDR_W'(LINE_PIX) + ADDR_W'(h_cnt_q >> SCALE);
    end
    act_pipe_d = {act_pipe_q[RD_LATENCY-1:0], active_c};
    hs_pipe_d  = {hs_pipe_q[RD_LATENCY-1:0], hsync_c};
    vs_pipe_d  = {vs_pipe_q[RD_LATENCY-1:0], vsync_c};
    fs_pipe_d  = {fs_pipe_q[RD_LATENCY-1:0], frame_start_c};
  end

  // Output stage: mask data outside active area, apply sync polarity
  always_comb begin
    pixel_d       = act_pipe_q[RD_LATENCY] ? fb.fb_rd_data : '0;
    hsync_d       = hs_pipe_q[RD_LATENCY] ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = vs_pipe_q[RD_LATENCY] ? VSYNC_POL : ~VSYNC_POL;
    frame_start_d = fs_pipe_q[RD_LATENCY];
  end

  always_ff @(posedge CLK_VGA or negedge reset) begin
    if (!reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      fb_rd_addr_q  <= '0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      fs_pipe_q     <= '0;
      pixel_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fb_rd_addr_q  <= fb_rd_addr_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      fs_pipe_q     <= fs_pipe_d;
      pixel_q       <= pixel_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign fb.fb_rd_en   = act_pipe_q[0];
  assign fb.fb_rd_addr = fb_rd_addr_q;
  assign VGA_pixel     = pixel_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign frame_start   = frame_start_q;

endmodule
